dbg_trace_monitor: RTL
======================

// Module: dbg_trace_monitor
// PURPOSE
//  Hardware successor to simulation-only register monitoring of the SoC debug taps (x10, x11, mcause,
//  mepc, mtval, ...). Watches NUM_CH debug channels and logs every value change as a
//  {channel, data, timestamp} entry in a DEPTH-entry FIFO, read out over a valid/ready port.
//  Supports continuous (overwrite-oldest) and one-shot (stop-when-full) capture.
// PARAMETERS
//  NUM_CH  5   number of monitored channels (>=1)
//  DATA_W  32  width of each channel
//  DEPTH   16  trace FIFO entries (power of 2, >=2)
//  TS_W    16  timestamp width; cycles since arm, saturating
//  CH_W = max(1,$clog2(NUM_CH)) and CNT_W = $clog2(DEPTH)+1 are localparams.
// PORTS
//  clk_in        in   1              single clock; all logic on rising edge
//  rst_n_in      in   1              asynchronous, active-low reset
//  ch_data_in    in   NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//  ch_en_in      in   NUM_CH         per-channel capture enable
//  arm_in        in   1              start a capture; clears FIFO, overflow and timestamp
//  stop_in       in   1              end the capture
//  mode_in       in   1              0 = continuous, 1 = one-shot; sampled on arm
//  rd_valid_out  out  1              head entry valid (count_out != 0)
//  rd_ready_in   in   1              consumer accepts head entry
//  rd_ch_out     out  CH_W           head entry channel index
//  rd_data_out   out  DATA_W         head entry channel value
//  rd_ts_out     out  TS_W           head entry timestamp
//  count_out     out  CNT_W          FIFO occupancy, 0..DEPTH
//  overflow_out  out  1              sticky: an entry was overwritten (continuous mode)
//  state_out     out  2              00 IDLE, 01 CAPTURE, 10 DONE
// BEHAVIOUR
//  - Reset (async assert): state IDLE, FIFO empty, all outputs 0, shadow regs 0, ts 0, mode 0.
//  - FSM: IDLE/DONE --arm_in--> CAPTURE. CAPTURE --stop_in--> IDLE.
//    CAPTURE --(one-shot, FIFO full, push pending)--> DONE. arm_in in CAPTURE is ignored.
//    stop_in beats arm_in when both are high in the same cycle.
//  - On the arm edge: shadow[i] <= ch_data_in[i] for all i, ts <= 0, FIFO pointers/count <= 0,
//    overflow_out <= 0, latch mode_in. No entry is generated for the arming snapshot.
//  - Change detect (CAPTURE only): chg[i] = ch_en_in[i] && (ch_data_in[i] != shadow[i]).
//    Each cycle push at most one entry: the lowest i with chg[i]. Then shadow[i] <= ch_data_in[i].
//    Entry = {i, ch_data_in[i], ts}. Other changed channels stay pending for later cycles.
//    A pending channel that returns to its shadow value before being pushed produces no entry.
//  - ts increments every cycle in CAPTURE and saturates at all-ones. It holds in IDLE and DONE.
//  - Latency: a push on edge t makes the entry visible (rd_valid_out=1, count_out updated) after edge t.
//  - Read port: first-word fall-through. Head fields are driven from FIFO storage.
//    Pop on an edge where rd_valid_out && rd_ready_in. Reads are allowed in every state.
//    Outputs hold stable while rd_valid_out && !rd_ready_in, except for the overwrite case below.
//  - Full FIFO, continuous mode, push without pop: oldest entry is dropped (read ptr advances),
//    new entry written, count stays DEPTH, overflow_out <= 1. The head changes.
//  - Full FIFO with push and pop in the same cycle: normal pop+push, no overflow, count stays DEPTH.
//  - Full FIFO, one-shot mode, push pending: no write, shadow not updated, state -> DONE.
//  - Empty FIFO with push and no pop: entry written. rd_ready_in while empty has no effect.
//  - Pointers wrap modulo DEPTH. count_out = pushes - pops.
//  - Reset asserted mid-capture or mid-read: immediate return to reset values; FIFO contents are discarded.
// TESTING
//  1. arm (ts=0), ch1 <= 0x1234 two cycles later -> one entry {ch=1,data=0x00001234,ts=2}, count_out=1.
//  2. ch0 and ch3 change in the same cycle t -> entries {0,..,ts=t} then {3,..,ts=t+1}, in that order.
//  3. DEPTH=4, continuous, 6 changes, no reads -> count_out=4, overflow_out=1, entries 3..6 remain in order.
//  4. DEPTH=4, one-shot, 5 changes -> state_out=DONE, count_out=4, 5th not logged. Re-arm -> count 0, CAPTURE.
//  5. Full FIFO with push and pop in the same cycle -> count_out stays 4, overflow_out stays 0.
//     Hold rd_ready_in=0 -> head fields stable.
//  6. ch_en_in[2]=0 and ch2 toggles -> no entry. stop_in then any change -> no entry.
//     rst_n_in low mid-capture -> all outputs 0, state_out=IDLE.

Source files
------------

// File: rtl/dbg_trace_monitor.sv
// rtl/dbg_trace_monitor.sv - debug channel change monitor with timestamped trace FIFO
module dbg_trace_monitor #(
  parameter int NUM_CH = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_in,
  input  logic [NUM_CH-1:0]        ch_en_in,
  input  logic                     arm_in,
  input  logic                     stop_in,
  input  logic                     mode_in,
  output logic                     rd_valid_out,
  input  logic                     rd_ready_in,
  output logic [CH_W-1:0]          rd_ch_out,
  output logic [DATA_W-1:0]        rd_data_out,
  output logic [TS_W-1:0]          rd_ts_out,
  output logic [CNT_W-1:0]         count_out,
  output logic                     overflow_out,
  output logic [1:0]               state_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_DONE    = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] shadow   [NUM_CH];
  logic [CH_W-1:0]   mem_ch   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [TS_W-1:0]   mem_ts   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [TS_W-1:0]   ts;
  logic              mode;
  logic              overflow;

  logic [NUM_CH-1:0] chg;
  logic              any_chg;
  logic [CH_W-1:0]   sel;
  logic [DATA_W-1:0] sel_data;
  logic              arm_go, push_req, full, pop, oneshot_block, do_write, overwrite;

  // Per-channel change flags against the shadow copy; only enabled channels count
  always_comb begin
    chg = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      chg[i] = ch_en_in[i] && (ch_data_in[i*DATA_W +: DATA_W] != shadow[i]);
    end
  end

  // Priority pick of the lowest-numbered changed channel; others wait for later cycles
  always_comb begin
    any_chg  = 1'b0;
    sel      = '0;
    sel_data = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chg[i]) begin
        any_chg  = 1'b1;
        sel      = CH_W'(i);
        sel_data = ch_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // stop_in wins over arm_in, and a stop edge ends capture without logging
  assign arm_go        = arm_in && !stop_in && (state != S_CAPTURE);
  assign push_req      = (state == S_CAPTURE) && !stop_in && any_chg;
  assign full          = (count == FULL_CNT);
  assign pop           = (count != '0) && rd_ready_in;
  assign oneshot_block = push_req && full && mode;
  assign do_write      = push_req && !oneshot_block;
  assign overwrite     = do_write && full && !pop;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state: arm starts capture, stop returns to idle, full one-shot freezes in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (arm_go) state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (stop_in)            state_nxt = S_IDLE;
        else if (oneshot_block) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: arm snapshot, timestamp, shadow update, FIFO write/pop/overwrite
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      for (int d = 0; d < DEPTH; d++) begin
        mem_ch[d]   <= '0;
        mem_data[d] <= '0;
        mem_ts[d]   <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      mode     <= 1'b0;
      overflow <= 1'b0;
    end else if (arm_go) begin
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= ch_data_in[i*DATA_W +: DATA_W];
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ts       <= '0;
      mode     <= mode_in;
      overflow <= 1'b0;
    end else begin
      if (state == S_CAPTURE && ts != '1) ts <= ts + 1'b1;
      if (do_write) begin
        mem_ch[wr_ptr]   <= sel;
        mem_data[wr_ptr] <= sel_data;
        mem_ts[wr_ptr]   <= ts;
        wr_ptr           <= wr_ptr + 1'b1;
        shadow[sel]      <= sel_data;
      end
      if (pop || overwrite) rd_ptr <= rd_ptr + 1'b1;
      if (overwrite) overflow <= 1'b1;
      if (do_write && !pop && !full) count <= count + 1'b1;
      else if (!do_write && pop)     count <= count - 1'b1;
    end
  end

  assign rd_valid_out = (count != '0);
  assign rd_ch_out    = mem_ch[rd_ptr];
  assign rd_data_out  = mem_data[rd_ptr];
  assign rd_ts_out    = mem_ts[rd_ptr];
  assign count_out    = count;
  assign overflow_out = overflow;
  assign state_out    = state;

endmodule
